// File: rtl/seq_pkg.sv
// Shared definitions for the serial burst generator and the benches that observe it.
// Holds the FSM state encoding and the default register widths.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int SEQ_PW = 8;
    localparam int SEQ_CW = 4;

endpackage

// File: rtl/seq_gen.sv
// Serial burst generator: sends pattern[len:0] MSB-first, reps times back to back,
// then pulses done for one cycle. All outputs are registered.
module seq_gen
    import seq_pkg::*;
#(
    parameter int PW = SEQ_PW,
    parameter int CW = SEQ_CW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [PW-1:0]         pattern,
    input  logic [$clog2(PW)-1:0] len,
    input  logic [CW-1:0]         reps,
    output logic                  dout,
    output logic                  dvalid,
    output logic                  busy,
    output logic                  done
);

    localparam int LW = $clog2(PW);

    seq_state_t    state;
    logic [PW-1:0] pat_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx;     // index of the bit currently on dout
    logic [CW-1:0] frames;  // frames still to send, including the current one

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset clears every register, including the captured operands,
        // so an aborted burst leaves nothing behind for the next one.
        if (!reset) begin
            state  <= IDLE;
            pat_q  <= '0;
            len_q  <= '0;
            idx    <= '0;
            frames <= '0;
            dout   <= 1'b0;
            dvalid <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    dout   <= 1'b0;
                    dvalid <= 1'b0;
                    busy   <= 1'b0;
                    if (start) begin
                        pat_q  <= pattern;
                        len_q  <= len;
                        idx    <= len;
                        frames <= (reps == '0) ? CW'(1) : reps;
                        // First bit goes out straight from the inputs to meet 1-cycle latency.
                        dout   <= pattern[len];
                        dvalid <= 1'b1;
                        busy   <= 1'b1;
                        state  <= SEND;
                    end
                end

                SEND: begin
                    if (idx == '0) begin
                        if (frames > CW'(1)) begin
                            frames <= frames - CW'(1);
                            idx    <= len_q;
                            dout   <= pat_q[len_q];
                            dvalid <= 1'b1;
                        end else begin
                            dout   <= 1'b0;
                            dvalid <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end else begin
                        idx  <= idx - LW'(1);
                        dout <= pat_q[idx - LW'(1)];
                    end
                end

                DONE: begin
                    // start seen here is deliberately dropped; the next burst needs a fresh request.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    dout   <= 1'b0;
                    dvalid <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: directed bursts plus randomized ones, compared
// against a bit queue built directly from pattern/len/reps.
module tb_seq_gen;
    import seq_pkg::*;

    localparam int PW = SEQ_PW;
    localparam int CW = SEQ_CW;
    localparam int LW = $clog2(PW);

    logic          clk;
    logic          reset;
    logic          start;
    logic [PW-1:0] pattern;
    logic [LW-1:0] len;
    logic [CW-1:0] reps;
    logic          dout;
    logic          dvalid;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;

    seq_gen #(.PW(PW), .CW(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .dout    (dout),
        .dvalid  (dvalid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".dout"},   32'(dout),   32'd0);
        check({tag, ".dvalid"}, 32'(dvalid), 32'd0);
        check({tag, ".busy"},   32'(busy),   32'd0);
        check({tag, ".done"},   32'(done),   32'd0);
    endtask

    // Called at a falling edge; returns at a falling edge with start low and the DUT idle.
    task automatic run_burst(input logic [PW-1:0] p, input int l, input int r, input bit disturb);
        bit exp_q[$];
        int nf;
        nf = (r == 0) ? 1 : r;
        for (int f = 0; f < nf; f++)
            for (int i = l; i >= 0; i--)
                exp_q.push_back(p[i]);

        start   = 1'b1;
        pattern = p;
        len     = LW'(l);
        reps    = CW'(r);
        @(negedge clk);

        foreach (exp_q[k]) begin
            check("bit.dvalid", 32'(dvalid), 32'd1);
            check("bit.dout",   32'(dout),   32'(exp_q[k]));
            check("bit.busy",   32'(busy),   32'd1);
            check("bit.done",   32'(done),   32'd0);
            if (disturb) begin
                start   = 1'($urandom);
                pattern = PW'($urandom);
                len     = LW'($urandom);
                reps    = CW'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end

        check("end.done",   32'(done),   32'd1);
        check("end.dvalid", 32'(dvalid), 32'd0);
        check("end.dout",   32'(dout),   32'd0);
        check("end.busy",   32'(busy),   32'd1);
        if (disturb) start = 1'b1;
        @(negedge clk);
        check_quiet("idle");
        start = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b1;
        pattern = '0;
        len     = '0;
        reps    = '0;
        @(negedge clk);
        @(negedge clk);
        check_quiet("reset");
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");

        run_burst(8'h0A, 3, 1, 1'b0);
        run_burst(8'hA5, 7, 3, 1'b0);
        run_burst(8'h01, 0, 0, 1'b0);
        run_burst(8'h5C, 5, 2, 1'b1);
        run_burst(8'hFE, 0, 2, 1'b0);

        for (int t = 0; t < 12; t++)
            run_burst(PW'($urandom), int'($urandom_range(PW - 1, 0)),
                      int'($urandom_range(3, 0)), 1'($urandom));

        // Abort on the third bit: 8'hB4 sends 1,0,1 first.
        start   = 1'b1;
        pattern = 8'hB4;
        len     = LW'(7);
        reps    = CW'(2);
        @(negedge clk);
        start = 1'b0;
        check("abort.bit1", 32'(dout), 32'd1);
        @(negedge clk);
        check("abort.bit2", 32'(dout), 32'd0);
        @(negedge clk);
        check("abort.bit3", 32'(dout), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_quiet("abort");
        reset = 1'b1;
        run_burst(8'h96, 4, 1, 1'b0);
        check_quiet("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
